// File: rtl/synth_pkg.sv
// Shared definitions for the synthesizer voice path: envelope state encoding
// and the full-scale envelope constant.
package synth_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } env_state_t;

   // Full-scale level; modules slice the low W bits (W <= 32).
   localparam int unsigned        ENV_MAX_W = 32;
   localparam logic [ENV_MAX_W-1:0] ENV_MAX  = 32'hFFFF_FFFF;

endpackage

// File: rtl/env_vca.sv
// Registered signed amplitude multiply: scales a signed oscillator sample by an
// unsigned envelope level and keeps the upper W bits of the product.
module env_vca #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] osc,
   input  logic [W-1:0] level,
   output logic [W-1:0] out,
   output logic         out_valid
);

   logic signed [2*W:0] osc_ext_s;
   logic signed [2*W:0] lvl_ext_s;
   logic signed [2*W:0] product_s;
   logic [W-1:0]        out_r;
   logic                out_valid_r;
   logic                unused_product_s;

   // Extend both operands to the full product width so the multiply is exact.
   always_comb begin
      osc_ext_s        = {{(W+1){osc[W-1]}}, osc};
      lvl_ext_s        = {{(W+1){1'b0}}, level};
      product_s        = osc_ext_s * lvl_ext_s;
      unused_product_s = ^{product_s[2*W], product_s[W-1:0]};
   end

   // Output register: the upper half is an arithmetic shift, i.e. floor rounding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_r       <= {W{1'b0}};
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= in_valid;
         if (in_valid) begin
            out_r <= product_s[2*W-1:W];
         end else begin
            out_r <= out_r;
         end
      end
   end

   assign out       = out_r;
   assign out_valid = out_valid_r;

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope generator: steps level/state once per audio sample, then
// scales the oscillator sample through a registered VCA stage.
module adsr_envelope
   import synth_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic         sample_en,
   input  logic         key_on,
   input  logic [W-1:0] attack_rate,
   input  logic [W-1:0] decay_rate,
   input  logic [W-1:0] sustain_level,
   input  logic [W-1:0] release_rate,
   input  logic [W-1:0] osc_in,
   output logic [W-1:0] out,
   output logic [W-1:0] env_level,
   output logic [2:0]   env_state,
   output logic         out_valid
);

   localparam logic [W-1:0] LVL_MAX = ENV_MAX[W-1:0];

   env_state_t   state_r;
   env_state_t   state_nxt_s;
   env_state_t   eff_state_s;
   logic [W-1:0] level_r;
   logic [W-1:0] level_nxt_s;
   logic [W-1:0] osc_r;
   logic         key_r;
   logic         s1_valid_r;
   logic         rise_s;
   logic         fall_s;
   logic [W:0]   att_sum_s;
   logic [W:0]   dec_floor_s;

   // Gate edges, then the state whose step applies in this sample.
   always_comb begin
      rise_s = key_on & ~key_r;
      fall_s = ~key_on & key_r;
      if (rise_s) begin
         eff_state_s = ATTACK;
      end else if (fall_s && (state_r == ATTACK || state_r == DECAY ||
                              state_r == SUSTAIN)) begin
         eff_state_s = RELEASE;
      end else begin
         eff_state_s = state_r;
      end
   end

   // Level step with one extra bit of headroom so clamps are decided exactly.
   always_comb begin
      att_sum_s   = {1'b0, level_r} + {1'b0, attack_rate};
      dec_floor_s = {1'b0, sustain_level} + {1'b0, decay_rate};
      level_nxt_s = {W{1'b0}};
      state_nxt_s = IDLE;
      case (eff_state_s)
         ATTACK: begin
            if (attack_rate == {W{1'b0}} || att_sum_s >= {1'b0, LVL_MAX}) begin
               level_nxt_s = LVL_MAX;
               state_nxt_s = DECAY;
            end else begin
               level_nxt_s = att_sum_s[W-1:0];
               state_nxt_s = ATTACK;
            end
         end
         DECAY: begin
            if (decay_rate == {W{1'b0}} || {1'b0, level_r} <= dec_floor_s) begin
               level_nxt_s = sustain_level;
               state_nxt_s = SUSTAIN;
            end else begin
               level_nxt_s = level_r - decay_rate;
               state_nxt_s = DECAY;
            end
         end
         SUSTAIN: begin
            level_nxt_s = sustain_level;
            state_nxt_s = SUSTAIN;
         end
         RELEASE: begin
            if (release_rate == {W{1'b0}} ||
                {1'b0, level_r} <= {1'b0, release_rate}) begin
               level_nxt_s = {W{1'b0}};
               state_nxt_s = IDLE;
            end else begin
               level_nxt_s = level_r - release_rate;
               state_nxt_s = RELEASE;
            end
         end
         IDLE: begin
            level_nxt_s = {W{1'b0}};
            state_nxt_s = IDLE;
         end
         default: begin
            level_nxt_s = {W{1'b0}};
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Stage 1: state, level, gate history and the oscillator sample paired with it.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_r    <= IDLE;
         level_r    <= {W{1'b0}};
         key_r      <= 1'b0;
         osc_r      <= {W{1'b0}};
         s1_valid_r <= 1'b0;
      end else if (sample_en) begin
         state_r    <= state_nxt_s;
         level_r    <= level_nxt_s;
         key_r      <= key_on;
         osc_r      <= osc_in;
         s1_valid_r <= 1'b1;
      end else begin
         s1_valid_r <= 1'b0;
      end
   end

   env_vca #(
      .W (W)
   ) u_vca (
      .clk       (Clk),
      .rst_n     (Reset_n),
      .in_valid  (s1_valid_r),
      .osc       (osc_r),
      .level     (level_r),
      .out       (out),
      .out_valid (out_valid)
   );

   assign env_level = level_r;
   assign env_state = state_r;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed and randomized bench for adsr_envelope against a behavioural
// envelope model built from the state rules with integer arithmetic.
module tb_adsr_envelope;

   logic        Clk;
   logic        Reset_n;
   logic        sample_en;
   logic        key_on;
   logic [15:0] attack_rate;
   logic [15:0] decay_rate;
   logic [15:0] sustain_level;
   logic [15:0] release_rate;
   logic [15:0] osc_in;
   logic [15:0] out;
   logic [15:0] env_level;
   logic [2:0]  env_state;
   logic        out_valid;

   int n_checks = 0;
   int n_pass   = 0;

   // Phase codes as listed in the interface description.
   localparam int P_IDLE = 0, P_ATT = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;
   localparam int FULL = 65535;

   int m_level = 0;
   int m_phase = P_IDLE;
   bit m_key   = 1'b0;
   int m_out   = 0;

   adsr_envelope #(.W(16)) dut (
      .Clk           (Clk),
      .Reset_n       (Reset_n),
      .sample_en     (sample_en),
      .key_on        (key_on),
      .attack_rate   (attack_rate),
      .decay_rate    (decay_rate),
      .sustain_level (sustain_level),
      .release_rate  (release_rate),
      .osc_in        (osc_in),
      .out           (out),
      .env_level     (env_level),
      .env_state     (env_state),
      .out_valid     (out_valid)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_level = 0;
      m_phase = P_IDLE;
      m_key   = 1'b0;
   endtask

   // One envelope step from the current inputs, plus the expected scaled sample.
   task automatic model_step();
      bit     rise;
      bit     fall;
      int     nl;
      longint p;
      rise  = key_on && !m_key;
      fall  = !key_on && m_key;
      m_key = key_on;
      if (rise) m_phase = P_ATT;
      else if (fall && (m_phase == P_ATT || m_phase == P_DEC || m_phase == P_SUS)) m_phase = P_REL;
      case (m_phase)
         P_ATT: begin
            nl = m_level + int'(attack_rate);
            if (attack_rate == 16'd0 || nl >= FULL) begin m_level = FULL; m_phase = P_DEC; end
            else m_level = nl;
         end
         P_DEC: begin
            nl = m_level - int'(decay_rate);
            if (decay_rate == 16'd0 || nl <= int'(sustain_level)) begin
               m_level = int'(sustain_level); m_phase = P_SUS;
            end else m_level = nl;
         end
         P_SUS: m_level = int'(sustain_level);
         P_REL: begin
            nl = m_level - int'(release_rate);
            if (release_rate == 16'd0 || nl <= 0) begin m_level = 0; m_phase = P_IDLE; end
            else m_level = nl;
         end
         default: m_level = 0;
      endcase
      p     = longint'($signed(osc_in)) * longint'(m_level);
      m_out = int'((p >>> 16) & 64'hFFFF);
   endtask

   // Entered 1 time unit after a rising edge; spans four clock cycles.
   task automatic do_sample(input logic k, input logic [15:0] osc);
      key_on    = k;
      osc_in    = osc;
      sample_en = 1'b1;
      @(posedge Clk);
      model_step();
      #1 sample_en = 1'b0;
      check("level", {16'h0, env_level}, 32'(m_level));
      check("state", {29'h0, env_state}, 32'(m_phase));
      check("valid_early", {31'h0, out_valid}, 32'h0);
      @(posedge Clk); #1;
      check("valid", {31'h0, out_valid}, 32'h1);
      check("out", {16'h0, out}, 32'(m_out));
      @(posedge Clk); #1;
      check("valid_drop", {31'h0, out_valid}, 32'h0);
      check("out_hold", {16'h0, out}, 32'(m_out));
      @(posedge Clk); #1;
   endtask

   initial begin
      int exp_a;
      Reset_n       = 1'b0;
      sample_en     = 1'b0;
      key_on        = 1'b1;
      attack_rate   = 16'h4000;
      decay_rate    = 16'h1000;
      sustain_level = 16'hE000;
      release_rate  = 16'h3000;
      osc_in        = 16'h7FFF;
      model_reset();
      repeat (3) @(posedge Clk);
      #1;
      check("rst_level", {16'h0, env_level}, 32'h0);
      check("rst_state", {29'h0, env_state}, 32'h0);
      check("rst_out", {16'h0, out}, 32'h0);
      check("rst_valid", {31'h0, out_valid}, 32'h0);
      Reset_n = 1'b1;
      @(posedge Clk); #1;

      // Attack ramp with key held through reset release.
      do_sample(1'b1, 16'h7FFF); check("vec_a1", {16'h0, env_level}, 32'h4000);
      do_sample(1'b1, 16'h7FFF); check("vec_a2", {16'h0, env_level}, 32'h8000);
      do_sample(1'b1, 16'h7FFF); check("vec_a3", {16'h0, env_level}, 32'hC000);
      do_sample(1'b1, 16'h7FFF); check("vec_a4", {16'h0, env_level}, 32'hFFFF);
      check("vec_a4_state", {29'h0, env_state}, 32'd2);
      check("vec_out_full", {16'h0, out}, 32'h7FFE);

      // Decay to sustain, then live sustain change.
      do_sample(1'b1, 16'h1234); check("vec_d1", {16'h0, env_level}, 32'hEFFF);
      do_sample(1'b1, 16'h1234); check("vec_d2", {16'h0, env_level}, 32'hE000);
      check("vec_d2_state", {29'h0, env_state}, 32'd3);
      sustain_level = 16'h8000;
      do_sample(1'b1, 16'h8000); check("vec_s", {16'h0, env_level}, 32'h8000);
      check("vec_out_neg", {16'h0, out}, 32'hC000);

      // Release to idle.
      do_sample(1'b0, 16'h4000); check("vec_r1", {16'h0, env_level}, 32'h5000);
      do_sample(1'b0, 16'h4000); check("vec_r2", {16'h0, env_level}, 32'h2000);
      do_sample(1'b0, 16'h4000); check("vec_r3", {16'h0, env_level}, 32'h0);
      check("vec_r3_state", {29'h0, env_state}, 32'd0);

      // Retrigger during release keeps the level.
      attack_rate = 16'h5000;
      do_sample(1'b1, 16'hC000);
      do_sample(1'b0, 16'hC000); check("vec_rt_rel", {16'h0, env_level}, 32'h2000);
      attack_rate = 16'h4000;
      do_sample(1'b1, 16'hC000); check("vec_rt_att", {16'h0, env_level}, 32'h6000);
      check("vec_rt_state", {29'h0, env_state}, 32'd1);

      // Zero rates jump straight to their targets.
      attack_rate = 16'h0;
      do_sample(1'b1, 16'h0100); check("zero_att", {16'h0, env_level}, 32'hFFFF);
      decay_rate = 16'h0; sustain_level = 16'hA000;
      do_sample(1'b1, 16'h0100); check("zero_dec", {16'h0, env_level}, 32'hA000);
      release_rate = 16'h0;
      do_sample(1'b0, 16'h0100); check("zero_rel", {16'h0, env_level}, 32'h0);
      check("zero_rel_state", {29'h0, env_state}, 32'd0);

      // Back-to-back samples.
      attack_rate = 16'h4000;
      key_on = 1'b1; osc_in = 16'(($urandom)); sample_en = 1'b1;
      @(posedge Clk); model_step(); exp_a = m_out;
      #1 osc_in = 16'($urandom);
      @(posedge Clk); model_step();
      #1 sample_en = 1'b0;
      check("b2b_valid_a", {31'h0, out_valid}, 32'h1);
      check("b2b_out_a", {16'h0, out}, 32'(exp_a));
      @(posedge Clk); #1;
      check("b2b_valid_b", {31'h0, out_valid}, 32'h1);
      check("b2b_out_b", {16'h0, out}, 32'(m_out));
      check("b2b_level", {16'h0, env_level}, 32'(m_level));
      @(posedge Clk); #1;
      check("b2b_drop", {31'h0, out_valid}, 32'h0);

      // Asynchronous reset mid-attack.
      do_sample(1'b1, 16'h7000);
      #2 Reset_n = 1'b0;
      #1;
      check("mid_rst_level", {16'h0, env_level}, 32'h0);
      check("mid_rst_state", {29'h0, env_state}, 32'h0);
      check("mid_rst_out", {16'h0, out}, 32'h0);
      check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
      model_reset();
      repeat (2) @(posedge Clk);
      #1 Reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge Clk); #1;
         check("post_rst_quiet", {31'h0, out_valid}, 32'h0);
      end
      do_sample(1'b1, 16'h7000); check("post_rst_att", {16'h0, env_level}, 32'h4000);

      // Randomized notes against the model.
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 5) == 0) key_on = ~key_on;
         attack_rate   = 16'($urandom_range(0, 32768));
         decay_rate    = 16'($urandom_range(0, 16384));
         release_rate  = 16'($urandom_range(0, 16384));
         if ($urandom_range(0, 3) == 0) sustain_level = 16'($urandom);
         do_sample(key_on, 16'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/adsr_envelope.md
ADSR_ENVELOPE -- requirements
Module: adsr_envelope

Interface
REQ-001 SHALL have parameter W, default 16: sample and envelope width.
REQ-002 SHALL have port Clk, input, 1: system clock (CLOCK_50 domain).
REQ-003 SHALL have port Reset_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port sample_en, input, 1: one-cycle pulse per audio sample; all envelope steps occur only on it.
REQ-005 SHALL have port key_on, input, 1: gate from the soc key_on register, level-sensitive.
REQ-006 SHALL have port attack_rate, input, W: unsigned level increment per sample in ATTACK.
REQ-007 SHALL have port decay_rate, input, W: unsigned level decrement per sample in DECAY.
REQ-008 SHALL have port sustain_level, input, W: unsigned SUSTAIN target.
REQ-009 SHALL have port release_rate, input, W: unsigned level decrement per sample in RELEASE.
REQ-010 SHALL have port osc_in, input, W: signed NCO output sample.
REQ-011 SHALL have port out, output, W: signed enveloped sample to audio_interface LDATA/RDATA.
REQ-012 SHALL have port env_level, output, W: current unsigned envelope level.
REQ-013 SHALL have port env_state, output, 3: current state encoding.
REQ-014 SHALL have port out_valid, output, 1: one-cycle pulse when out updates.

Function
REQ-015 SHALL implement states IDLE, ATTACK, DECAY, SUSTAIN, RELEASE; state and level change only in cycles where sample_en=1.
REQ-016 SHALL register key_on on each sample_en and detect rising/falling edges against the previous registered value.
REQ-017 SHALL enter ATTACK on a key_on rising edge from any state, keeping the current level (no reset to zero).
REQ-018 SHALL enter RELEASE on a key_on falling edge from ATTACK, DECAY or SUSTAIN; rising edge wins if both edges are impossible to coexist, and a rising edge takes priority over any rate transition in the same sample.
REQ-019 ATTACK: level += attack_rate, saturating at 2^W-1; on reaching 2^W-1 SHALL move to DECAY; attack_rate=0 SHALL jump level to 2^W-1 in one sample.
REQ-020 DECAY: level -= decay_rate, clamped at sustain_level; on reaching sustain_level SHALL move to SUSTAIN; decay_rate=0 SHALL jump to sustain_level.
REQ-021 SUSTAIN: level SHALL track sustain_level each sample (live parameter change follows immediately).
REQ-022 RELEASE: level -= release_rate, clamped at 0; on reaching 0 SHALL move to IDLE; release_rate=0 SHALL jump to 0.
REQ-023 IDLE: level SHALL be 0; key_on held high at reset release SHALL count as a rising edge on first sample_en.
REQ-024 Arithmetic SHALL use W+1-bit intermediates so add/subtract wrap-around never occurs.
REQ-025 out SHALL equal bits [2W-1:W] of signed(osc_in) x signed({1'b0,env_level}) computed with the level updated in the same sample, truncation toward minus infinity.
REQ-026 out and out_valid SHALL update exactly 2 Clk cycles after the sample_en cycle (stage 1: level/state, stage 2: multiply); out holds between updates.
REQ-027 sample_en asserted on consecutive cycles SHALL each be processed; pipeline accepts one sample per cycle.

Reset
REQ-028 Reset_n low SHALL asynchronously force state IDLE, env_level 0, out 0, out_valid 0, registered key_on 0, pipeline registers 0.
REQ-029 Reset asserted mid-note SHALL abort with no further out_valid until after reset release and a new sample_en.

Structure
REQ-030 env_state_t enum (IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4) and ENV_MAX constant SHALL live in shared package synth_pkg.
REQ-031 The signed amplitude multiply stage SHALL be a sub-module named env_vca (registered, 1-cycle latency).

Verification
REQ-032 Reset, key_on=1, attack_rate=16'h4000, sample_en every 4 cycles -> env_level 4000,8000,C000,FFFF, then DECAY.
REQ-033 In DECAY, decay_rate=16'h1000, sustain_level=16'hE000 -> EFFF then E000, state SUSTAIN; change sustain_level to 8000 -> env_level 8000 next sample.
REQ-034 key_on 1->0 in SUSTAIN at 8000, release_rate=16'h3000 -> 5000,2000,0000, state IDLE.
REQ-035 osc_in=16'h7FFF, env_level=FFFF -> out=7FFE; osc_in=16'h8000, env 8000 -> out=C000; out_valid 2 cycles after sample_en.
REQ-036 key_on re-raised in RELEASE at level 2000 -> ATTACK from 2000, not 0; Reset_n pulsed low mid-ATTACK -> all outputs 0 immediately.
